// File: rtl/umi_write_arbiter.sv
// umi_write_arbiter: round-robin arbiter that merges N single-beat UMI packet
// streams into one registered output port. The output buffer reloads in the
// same cycle it drains, so a steady stream runs at one packet per cycle.

module umi_write_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*DW-1:0] in_packet,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [DW-1:0]   umi_packet,
    output logic            umi_valid,
    input  logic            umi_ready
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(N - 1);

    // Output buffer and round-robin priority pointer
    logic            buf_valid_q;
    logic [DW-1:0]   buf_packet_q;
    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;

    // Arbitration results
    logic            load;
    logic            any_req;
    logic [N-1:0]    gnt;
    logic [PtrW-1:0] gnt_idx;
    logic [DW-1:0]   gnt_packet;

    // The buffer can take a new packet when empty or when it drains this cycle
    assign load = ~buf_valid_q | umi_ready;

    // Rotating priority search starting at ptr; wrap is an explicit modulo N so
    // a non-power-of-two N never reaches an index beyond N-1
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any_req = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_req && in_valid[idx]) begin
                any_req      = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx[PtrW-1:0];
            end
        end
    end

    // AND-OR packet mux driven by the one-hot grant
    always_comb begin
        gnt_packet = '0;
        for (int unsigned i = 0; i < N; i++) begin
            gnt_packet = gnt_packet | (in_packet[i*DW +: DW] & {DW{gnt[i]}});
        end
    end

    // Pointer moves to the slot just after the winner, wrapping at N-1
    always_comb begin
        if (gnt_idx == LastIdx) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx + 1'b1;
        end
    end

    // Grant is visible only when the buffer can load; held low during reset
    assign in_ready = gnt & {N{load & rst}};

    // Buffer load/drain and pointer update; idle cycles leave ptr untouched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q  <= 1'b0;
            buf_packet_q <= '0;
            ptr_q        <= '0;
        end else if (load) begin
            if (any_req) begin
                buf_valid_q  <= 1'b1;
                buf_packet_q <= gnt_packet;
                ptr_q        <= ptr_d;
            end else begin
                buf_valid_q  <= 1'b0;
            end
        end
    end

    assign umi_valid  = buf_valid_q;
    assign umi_packet = buf_packet_q;

    // At most one requester is accepted per cycle
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(in_ready));

    // A stalled output stays put and no requester is accepted
    a_stall_hold: assert property (@(posedge clk) disable iff (!rst)
        (umi_valid && !umi_ready) |=> (umi_valid && $stable(umi_packet)));

    a_stall_no_ready: assert property (@(posedge clk) disable iff (!rst)
        (umi_valid && !umi_ready) |-> (in_ready == '0));

    // Pointer always names a real requester
    a_ptr_range: assert property (@(posedge clk) disable iff (!rst) (int'(ptr_q) < N));

endmodule

// File: tb/tb_umi_write_arbiter.sv
// Self-checking bench for umi_write_arbiter: directed scenarios plus a random
// run, all compared against a queue-free behavioural round-robin model.

module tb_umi_write_arbiter;

    localparam int N   = 4;
    localparam int DW  = 256;
    localparam int N3  = 3;
    localparam int DW3 = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] in_packet;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   umi_packet;
    logic            umi_valid;
    logic            umi_ready;

    logic              rst3;
    logic [N3*DW3-1:0] in_packet3;
    logic [N3-1:0]     in_valid3;
    logic [N3-1:0]     in_ready3;
    logic [DW3-1:0]    umi_packet3;
    logic              umi_valid3;
    logic              umi_ready3;

    always #5 clk = ~clk;

    umi_write_arbiter #(.N(N), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_packet  (in_packet),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .umi_packet (umi_packet),
        .umi_valid  (umi_valid),
        .umi_ready  (umi_ready)
    );

    umi_write_arbiter #(.N(N3), .DW(DW3)) dut3 (
        .clk        (clk),
        .rst        (rst3),
        .in_packet  (in_packet3),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .umi_packet (umi_packet3),
        .umi_valid  (umi_valid3),
        .umi_ready  (umi_ready3)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit            m_valid;
    logic [DW-1:0] m_packet;
    int            m_ptr;

    // Per-step observations and expectations
    logic [N-1:0] obs_ready;
    logic [N-1:0] exp_ready;
    int           last_win;

    // First valid requester scanning from p upward, modulo N
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_pkt(input int i, input logic [DW-1:0] val);
        in_packet[i*DW +: DW] = val;
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_packet = '0;
        m_ptr    = 0;
    endtask

    // One clock: drive inputs, sample in_ready, advance the model, sample after edge
    task automatic step(input logic [N-1:0] v, input logic r);
        int  w;
        bit  ld;
        @(negedge clk);
        in_valid  = v;
        umi_ready = r;
        #1;
        w  = pick(v, m_ptr);
        ld = !m_valid || r;
        exp_ready = (ld && w >= 0) ? (N'(1) << w) : '0;
        obs_ready = in_ready;
        last_win  = -1;
        if (ld) begin
            if (w >= 0) begin
                m_valid  = 1'b1;
                m_packet = in_packet[w*DW +: DW];
                m_ptr    = (w + 1) % N;
                last_win = w;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = '1;
        umi_ready = 1'b1;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = '0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = '1;
        #1;
        checks++;
        if (in_ready !== '0) begin
            failures++;
            $display("FAIL reset_in_ready got %b exp 0", in_ready);
        end
        checks++;
        if (umi_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_umi_valid got %b exp 0", umi_valid);
        end
        checks++;
        if (umi_packet !== '0) begin
            failures++;
            $display("FAIL reset_umi_packet got %h exp 0", umi_packet);
        end
        checks++;
        if (int'(dut.ptr_q) !== 0) begin
            failures++;
            $display("FAIL reset_ptr got %0d exp 0", dut.ptr_q);
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = '0;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        for (int s = 0; s < 3; s++) begin
            set_pkt(2, DW'(8'hA0 + s));
            step(4'b0100, 1'b1);
            checks++;
            if (obs_ready !== 4'b0100) begin
                failures++;
                $display("FAIL single_ready[%0d] got %b exp 0100", s, obs_ready);
            end
            checks++;
            if (umi_valid !== 1'b1 || umi_packet !== DW'(8'hA0 + s)) begin
                failures++;
                $display("FAIL single_packet[%0d] got %b/%h exp 1/%h", s, umi_valid,
                         umi_packet, 8'hA0 + s);
            end
        end
        checks++;
        if (int'(dut.ptr_q) !== 3) begin
            failures++;
            $display("FAIL single_ptr got %0d exp 3", dut.ptr_q);
        end
        step(4'b0000, 1'b1);
    endtask

    task automatic test_contention();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < N; i++) set_pkt(i, DW'(32'hC000_0000 | (s << 8) | i));
            step(4'b1111, 1'b1);
            checks++;
            if (last_win !== order[s] || obs_ready !== (N'(1) << order[s])) begin
                failures++;
                $display("FAIL contention_grant[%0d] got %b exp winner %0d", s, obs_ready,
                         order[s]);
            end
            checks++;
            if (umi_valid !== 1'b1 ||
                umi_packet !== DW'(32'hC000_0000 | (s << 8) | order[s])) begin
                failures++;
                $display("FAIL contention_out[%0d] got %b/%h", s, umi_valid, umi_packet);
            end
        end
        step(4'b0000, 1'b1);
    endtask

    task automatic test_sparse_wrap();
        int order [2] = '{0, 1};
        do_reset();
        set_pkt(2, DW'(8'h22));
        step(4'b0100, 1'b1);
        checks++;
        if (int'(dut.ptr_q) !== 3) begin
            failures++;
            $display("FAIL wrap_ptr got %0d exp 3", dut.ptr_q);
        end
        set_pkt(0, DW'(8'h30));
        set_pkt(1, DW'(8'h31));
        for (int s = 0; s < 2; s++) begin
            step(4'b0011, 1'b1);
            checks++;
            if (obs_ready !== (N'(1) << order[s]) || umi_packet !== DW'(8'h30 + order[s])) begin
                failures++;
                $display("FAIL wrap_grant[%0d] got %b/%h exp winner %0d", s, obs_ready,
                         umi_packet, order[s]);
            end
        end
        step(4'b0000, 1'b1);
    endtask

    task automatic test_backpressure();
        do_reset();
        set_pkt(0, DW'(8'h55));
        step(4'b0001, 1'b1);
        set_pkt(1, DW'(8'h71));
        set_pkt(3, DW'(8'h73));
        for (int s = 0; s < 5; s++) begin
            step(4'b1010, 1'b0);
            checks++;
            if (obs_ready !== '0 || umi_valid !== 1'b1 || umi_packet !== DW'(8'h55)) begin
                failures++;
                $display("FAIL backpressure_hold[%0d] got rdy=%b v=%b pkt=%h exp 0/1/55", s,
                         obs_ready, umi_valid, umi_packet);
            end
        end
        step(4'b1010, 1'b1);
        checks++;
        if (obs_ready !== 4'b0010 || umi_valid !== 1'b1 || umi_packet !== DW'(8'h71)) begin
            failures++;
            $display("FAIL backpressure_release got rdy=%b v=%b pkt=%h exp 0010/1/71",
                     obs_ready, umi_valid, umi_packet);
        end
        step(4'b0000, 1'b1);
    endtask

    task automatic test_withdrawal();
        do_reset();
        set_pkt(0, DW'(8'h11));
        set_pkt(1, DW'(8'h99));
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b0);
        checks++;
        if (obs_ready !== '0 || umi_packet !== DW'(8'h11)) begin
            failures++;
            $display("FAIL withdraw_stall got rdy=%b pkt=%h exp 0/11", obs_ready, umi_packet);
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        checks++;
        if (obs_ready !== '0 || umi_valid !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_drain got rdy=%b v=%b exp 0/0", obs_ready, umi_valid);
        end
        for (int s = 0; s < 3; s++) begin
            step(4'b0000, 1'($urandom_range(0, 1)));
            checks++;
            if (int'(dut.ptr_q) !== 1 || umi_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_ptr[%0d] got ptr=%0d v=%b exp 1/0", s, dut.ptr_q,
                         umi_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_pkt(1, DW'(8'hB1));
        set_pkt(2, DW'(8'hB2));
        step(4'b0010, 1'b1);
        checks++;
        if (umi_valid !== 1'b1 || int'(dut.ptr_q) !== 2) begin
            failures++;
            $display("FAIL midreset_setup got v=%b ptr=%0d exp 1/2", umi_valid, dut.ptr_q);
        end
        in_valid  = 4'b1111;
        umi_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (umi_valid !== 1'b0 || umi_packet !== '0 || int'(dut.ptr_q) !== 0 ||
            in_ready !== '0) begin
            failures++;
            $display("FAIL midreset_clear got v=%b pkt=%h ptr=%0d rdy=%b exp all 0",
                     umi_valid, umi_packet, dut.ptr_q, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(4'b0110, 1'b1);
        checks++;
        if (obs_ready !== 4'b0010 || umi_packet !== DW'(8'hB1)) begin
            failures++;
            $display("FAIL midreset_first got rdy=%b pkt=%h exp 0010/b1", obs_ready,
                     umi_packet);
        end
        step(4'b0000, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        for (int s = 0; s < 300; s++) begin
            for (int w = 0; w < N * DW / 32; w++) in_packet[w*32 +: 32] = $urandom;
            step(N'($urandom), 1'($urandom_range(0, 3) != 0));
            checks++;
            if (obs_ready !== exp_ready) begin
                failures++;
                $display("FAIL random_ready[%0d] got %b exp %b", s, obs_ready, exp_ready);
            end
            checks++;
            if (umi_valid !== m_valid || umi_packet !== m_packet) begin
                failures++;
                $display("FAIL random_out[%0d] got %b/%h exp %b/%h", s, umi_valid,
                         umi_packet, m_valid, m_packet);
            end
            checks++;
            if (int'(dut.ptr_q) !== m_ptr) begin
                failures++;
                $display("FAIL random_ptr[%0d] got %0d exp %0d", s, dut.ptr_q, m_ptr);
            end
        end
    endtask

    task automatic test_n3();
        logic [N3-1:0]  req  [3] = '{3'b100, 3'b011, 3'b011};
        logic [N3-1:0]  rdy  [3] = '{3'b100, 3'b001, 3'b010};
        logic [DW3-1:0] pkt  [3] = '{16'h00C2, 16'h00C0, 16'h00C1};
        int             ptr  [3] = '{0, 1, 2};
        @(negedge clk);
        rst3       = 1'b1;
        umi_ready3 = 1'b1;
        in_packet3 = {16'h00C2, 16'h00C1, 16'h00C0};
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            in_valid3 = req[s];
            #1;
            checks++;
            if (in_ready3 !== rdy[s]) begin
                failures++;
                $display("FAIL n3_ready[%0d] got %b exp %b", s, in_ready3, rdy[s]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (umi_valid3 !== 1'b1 || umi_packet3 !== pkt[s] || int'(dut3.ptr_q) !== ptr[s]) begin
                failures++;
                $display("FAIL n3_out[%0d] got %b/%h ptr=%0d exp 1/%h ptr=%0d", s, umi_valid3,
                         umi_packet3, dut3.ptr_q, pkt[s], ptr[s]);
            end
        end
        @(negedge clk);
        in_valid3 = '0;
    endtask

    initial begin
        rst        = 1'b0;
        in_packet  = '0;
        in_valid   = '0;
        umi_ready  = 1'b0;
        rst3       = 1'b0;
        in_packet3 = '0;
        in_valid3  = '0;
        umi_ready3 = 1'b1;
        obs_ready  = '0;
        exp_ready  = '0;
        last_win   = -1;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_sparse_wrap();
        test_backpressure();
        test_withdrawal();
        test_reset_mid();
        test_random();
        test_n3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
